// File: rtl/rx_hp_wr_addr_gen.sv
// Huge-page write address allocator: carves per-frame qword slots out of two alternating driver huge pages.
// Optional idle force-close of partially filled pages is enabled with `define RX_HP_TIMEOUT_EN.
module rx_hp_wr_addr_gen #(
    parameter int          HP_BYTES_LOG2 = 21,
    parameter int          HDR_QW        = 8,
    parameter logic [15:0] TIMEOUT_CYC   = 16'd25000
) (
    input  logic                     trn_clk,
    input  logic                     reset,
    input  logic [63:0]              huge_page_addr_1,
    input  logic [63:0]              huge_page_addr_2,
    input  logic                     huge_page_status_1,
    input  logic                     huge_page_status_2,
    output logic                     huge_page_free_1,
    output logic                     huge_page_free_2,
    input  logic                     pkt_req,
    input  logic [8:0]               pkt_len_qw,
    output logic                     pkt_gnt,
    output logic [63:0]              pkt_addr,
    input  logic                     dma_idle,
    output logic                     close_valid,
    output logic                     close_page,
    output logic [HP_BYTES_LOG2-4:0] close_qw
);

    localparam int OFF_W = HP_BYTES_LOG2 - 2;
    localparam int CQ_W  = HP_BYTES_LOG2 - 3;
    localparam logic [OFF_W-1:0] HP_QW_C  = OFF_W'(1) << CQ_W;
    localparam logic [OFF_W-1:0] HDR_QW_C = OFF_W'(HDR_QW);

    localparam logic [2:0] WAIT1  = 3'd0;
    localparam logic [2:0] ACT1   = 3'd1;
    localparam logic [2:0] CLOSE1 = 3'd2;
    localparam logic [2:0] WAIT2  = 3'd3;
    localparam logic [2:0] ACT2   = 3'd4;
    localparam logic [2:0] CLOSE2 = 3'd5;

    logic [2:0]       state_r,     state_nxt_s;
    logic [63:0]      base_r,      base_nxt_s;
    logic [OFF_W-1:0] offset_r,    offset_nxt_s;
    logic             pkt_gnt_r,   gnt_nxt_s;
    logic [63:0]      pkt_addr_r,  addr_nxt_s;
    logic             free_1_r,    free_1_nxt_s;
    logic             free_2_r,    free_2_nxt_s;
    logic             close_vld_r, close_vld_nxt_s;
    logic             close_pg_r,  close_pg_nxt_s;
    logic [CQ_W-1:0]  close_qw_r,  close_qw_nxt_s;
    logic [OFF_W-1:0] sum_s;
    logic             fit_s;
    logic [2:0]       close_of_act_s;
`ifdef RX_HP_TIMEOUT_EN
    logic [15:0]      idle_cnt_r,  idle_nxt_s;
`else
    logic             unused_timeout_s;
    assign unused_timeout_s = ^TIMEOUT_CYC;
`endif

    // Offset arithmetic is one bit wider than a page so an overflowing frame cannot wrap into a false fit.
    assign sum_s          = offset_r + OFF_W'(pkt_len_qw);
    assign fit_s          = (sum_s <= HP_QW_C);
    assign close_of_act_s = (state_r == ACT1) ? CLOSE1 : CLOSE2;

    // Next-state and next-output computation for the page alternation FSM.
    always_comb begin
        state_nxt_s     = state_r;
        base_nxt_s      = base_r;
        offset_nxt_s    = offset_r;
        gnt_nxt_s       = 1'b0;
        addr_nxt_s      = pkt_addr_r;
        free_1_nxt_s    = 1'b0;
        free_2_nxt_s    = 1'b0;
        close_vld_nxt_s = 1'b0;
        close_pg_nxt_s  = close_pg_r;
        close_qw_nxt_s  = close_qw_r;
`ifdef RX_HP_TIMEOUT_EN
        idle_nxt_s      = idle_cnt_r;
`endif
        case (state_r)
            WAIT1: begin
                if (huge_page_status_1) begin
                    base_nxt_s   = huge_page_addr_1;
                    offset_nxt_s = HDR_QW_C;
                    state_nxt_s  = ACT1;
`ifdef RX_HP_TIMEOUT_EN
                    idle_nxt_s   = 16'd0;
`endif
                end else begin
                    state_nxt_s = WAIT1;
                end
            end
            WAIT2: begin
                if (huge_page_status_2) begin
                    base_nxt_s   = huge_page_addr_2;
                    offset_nxt_s = HDR_QW_C;
                    state_nxt_s  = ACT2;
`ifdef RX_HP_TIMEOUT_EN
                    idle_nxt_s   = 16'd0;
`endif
                end else begin
                    state_nxt_s = WAIT2;
                end
            end
            ACT1, ACT2: begin
                // A request seen during the grant pulse is the one just served, so it is skipped.
                if (pkt_req && !pkt_gnt_r) begin
                    if (fit_s) begin
                        gnt_nxt_s    = 1'b1;
                        addr_nxt_s   = base_r + {{(64-OFF_W-3){1'b0}}, offset_r, 3'b000};
                        offset_nxt_s = sum_s;
`ifdef RX_HP_TIMEOUT_EN
                        idle_nxt_s   = 16'd0;
`endif
                        if (sum_s == HP_QW_C) begin
                            state_nxt_s = close_of_act_s;
                        end else begin
                            state_nxt_s = state_r;
                        end
                    end else begin
                        state_nxt_s = close_of_act_s;
                    end
                end else begin
`ifdef RX_HP_TIMEOUT_EN
                    if (offset_r > HDR_QW_C) begin
                        if ((idle_cnt_r + 16'd1) >= TIMEOUT_CYC) begin
                            state_nxt_s = close_of_act_s;
                        end else begin
                            idle_nxt_s = idle_cnt_r + 16'd1;
                        end
                    end else begin
                        idle_nxt_s = 16'd0;
                    end
`else
                    state_nxt_s = state_r;
`endif
                end
            end
            CLOSE1: begin
                if (dma_idle) begin
                    free_1_nxt_s    = 1'b1;
                    close_vld_nxt_s = 1'b1;
                    close_pg_nxt_s  = 1'b0;
                    close_qw_nxt_s  = CQ_W'(offset_r - HDR_QW_C);
                    state_nxt_s     = WAIT2;
                end else begin
                    state_nxt_s = CLOSE1;
                end
            end
            CLOSE2: begin
                if (dma_idle) begin
                    free_2_nxt_s    = 1'b1;
                    close_vld_nxt_s = 1'b1;
                    close_pg_nxt_s  = 1'b1;
                    close_qw_nxt_s  = CQ_W'(offset_r - HDR_QW_C);
                    state_nxt_s     = WAIT1;
                end else begin
                    state_nxt_s = CLOSE2;
                end
            end
            default: begin
                state_nxt_s = WAIT1;
            end
        endcase
    end

    // State and registered outputs; reset drops any open page without returning it.
    always_ff @(posedge trn_clk) begin
        if (reset) begin
            state_r     <= WAIT1;
            base_r      <= 64'd0;
            offset_r    <= {OFF_W{1'b0}};
            pkt_gnt_r   <= 1'b0;
            pkt_addr_r  <= 64'd0;
            free_1_r    <= 1'b0;
            free_2_r    <= 1'b0;
            close_vld_r <= 1'b0;
            close_pg_r  <= 1'b0;
            close_qw_r  <= {CQ_W{1'b0}};
`ifdef RX_HP_TIMEOUT_EN
            idle_cnt_r  <= 16'd0;
`endif
        end else begin
            state_r     <= state_nxt_s;
            base_r      <= base_nxt_s;
            offset_r    <= offset_nxt_s;
            pkt_gnt_r   <= gnt_nxt_s;
            pkt_addr_r  <= addr_nxt_s;
            free_1_r    <= free_1_nxt_s;
            free_2_r    <= free_2_nxt_s;
            close_vld_r <= close_vld_nxt_s;
            close_pg_r  <= close_pg_nxt_s;
            close_qw_r  <= close_qw_nxt_s;
`ifdef RX_HP_TIMEOUT_EN
            idle_cnt_r  <= idle_nxt_s;
`endif
        end
    end

    assign pkt_gnt          = pkt_gnt_r;
    assign pkt_addr         = pkt_addr_r;
    assign huge_page_free_1 = free_1_r;
    assign huge_page_free_2 = free_2_r;
    assign close_valid      = close_vld_r;
    assign close_page       = close_pg_r;
    assign close_qw         = close_qw_r;

endmodule
